// File: rtl/snn_layer_scheduler.sv
// Sequences NEURONS virtual neurons through one shared leaky-integrator datapath,
// one neuron per cycle, and collects the thresholded results into a spike vector.
module snn_layer_scheduler #(
    parameter int NEURONS       = 8,
    parameter int SYNAPSES      = 8,
    parameter int MEMBRANE_BITS = $clog2(SYNAPSES) + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic        [SYNAPSES-1:0]      in_spikes,
    input  logic        [2:0]               shift_cfg,
    input  logic signed [MEMBRANE_BITS-1:0] bias_cfg,
    input  logic signed [MEMBRANE_BITS-1:0] threshold,
    input  logic                            wr_en,
    input  logic        [$clog2(NEURONS)-1:0] wr_addr,
    input  logic        [SYNAPSES-1:0]      wr_data,
    output logic                            wr_ready,
    output logic        [SYNAPSES-1:0]      dp_inputs,
    output logic        [SYNAPSES-1:0]      dp_weights,
    output logic        [2:0]               dp_shift,
    output logic signed [MEMBRANE_BITS-1:0] dp_bias,
    output logic signed [MEMBRANE_BITS-1:0] dp_last_membrane,
    input  logic signed [MEMBRANE_BITS-1:0] dp_new_membrane,
    output logic                            busy,
    output logic                            done,
    output logic        [NEURONS-1:0]       out_spikes
);
    localparam int IW = $clog2(NEURONS);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                          state;
    logic [IW-1:0]                   idx;
    logic [SYNAPSES-1:0]             weights  [NEURONS];
    logic signed [MEMBRANE_BITS-1:0] membrane [NEURONS];
    logic [SYNAPSES-1:0]             lat_spikes;
    logic [2:0]                      lat_shift;
    logic signed [MEMBRANE_BITS-1:0] lat_bias;
    logic signed [MEMBRANE_BITS-1:0] lat_thr;
    logic [NEURONS-1:0]              acc;
    logic [NEURONS-1:0]              acc_next;
    logic                            fire;

    // The datapath sees a neuron only while RUN; otherwise its inputs are parked at zero.
    always_comb begin
        dp_inputs        = '0;
        dp_weights       = '0;
        dp_shift         = '0;
        dp_bias          = '0;
        dp_last_membrane = '0;
        if (state == RUN) begin
            dp_inputs        = lat_spikes;
            dp_weights       = weights[idx];
            dp_shift         = lat_shift;
            dp_bias          = lat_bias;
            dp_last_membrane = membrane[idx];
        end
    end

    always_comb begin
        fire          = (state == RUN) && (dp_new_membrane >= lat_thr);
        acc_next      = acc;
        acc_next[idx] = fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            lat_spikes <= '0;
            lat_shift  <= '0;
            lat_bias   <= '0;
            lat_thr    <= '0;
            out_spikes <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ready   <= 1'b1;
            for (int i = 0; i < NEURONS; i++) begin
                weights[i]  <= '0;
                membrane[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (wr_en) weights[wr_addr] <= wr_data;
                    if (start) begin
                        lat_spikes <= in_spikes;
                        lat_shift  <= shift_cfg;
                        lat_bias   <= bias_cfg;
                        lat_thr    <= threshold;
                        acc        <= '0;
                        idx        <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                        wr_ready   <= 1'b0;
                    end
                end
                RUN: begin
                    acc           <= acc_next;
                    // Reset by subtraction keeps the overshoot above threshold.
                    membrane[idx] <= fire ? dp_new_membrane - lat_thr : dp_new_membrane;
                    idx           <= idx + 1'b1;
                    if (idx == IW'(NEURONS - 1)) begin
                        state      <= FINISH;
                        done       <= 1'b1;
                        out_spikes <= acc_next;
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Self-checking bench for snn_layer_scheduler: directed vector table, hand-written
// corner sequences, and randomized timesteps against a behavioural layer model.
module tb_snn_layer_scheduler;
    localparam int N  = 8;
    localparam int S  = 8;
    localparam int MB = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [S-1:0]         in_spikes = '0;
    logic [2:0]           shift_cfg = '0;
    logic signed [MB-1:0] bias_cfg = '0;
    logic signed [MB-1:0] threshold = 5'sd3;
    logic                 wr_en = 1'b0;
    logic [2:0]           wr_addr = '0;
    logic [S-1:0]         wr_data = '0;
    logic                 wr_ready;
    logic [S-1:0]         dp_inputs;
    logic [S-1:0]         dp_weights;
    logic [2:0]           dp_shift;
    logic signed [MB-1:0] dp_bias;
    logic signed [MB-1:0] dp_last_membrane;
    logic signed [MB-1:0] dp_new_membrane;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         out_spikes;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] exp_q[$];

    // Captures of what the datapath saw in each RUN cycle, indexed by cycle.
    logic [S-1:0]         cap_w    [N];
    logic [S-1:0]         cap_in   [N];
    logic signed [MB-1:0] cap_last [N];
    logic signed [MB-1:0] cap_bias [N];
    logic [N-1:0]         cap_spk;

    // Reference layer state.
    logic [S-1:0] m_w   [N];
    int           m_mem [N];
    int           exp_last [N];
    logic [S-1:0] exp_w [N];

    typedef struct {
        logic [S-1:0]         spk;
        logic [2:0]           sh;
        logic signed [MB-1:0] b;
        logic signed [MB-1:0] thr;
        logic [N-1:0]         exp;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    // Saturating leaky integrator standing in for the shared datapath.
    function automatic int dp_model(int last, logic [S-1:0] spk, logic [S-1:0] w, int sh, int b);
        int v;
        v = (last >>> sh) + $countones(spk & w) + b;
        if (v > 15) v = 15;
        if (v < -16) v = -16;
        return v;
    endfunction

    assign dp_new_membrane = MB'(dp_model(int'(dp_last_membrane), dp_inputs, dp_weights,
                                          int'(dp_shift), int'(dp_bias)));

    snn_layer_scheduler #(.NEURONS(N), .SYNAPSES(S), .MEMBRANE_BITS(MB)) dut (
        .clk(clk), .reset(reset), .start(start), .in_spikes(in_spikes),
        .shift_cfg(shift_cfg), .bias_cfg(bias_cfg), .threshold(threshold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .dp_inputs(dp_inputs), .dp_weights(dp_weights), .dp_shift(dp_shift),
        .dp_bias(dp_bias), .dp_last_membrane(dp_last_membrane),
        .dp_new_membrane(dp_new_membrane), .busy(busy), .done(done),
        .out_spikes(out_spikes)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < N; n++) begin
            m_w[n]   = '0;
            m_mem[n] = 0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [S-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_w[a] = d;
    endtask

    // One timestep: start at a negedge, then capture datapath traffic until done.
    task automatic run_step(input logic [S-1:0] spk, input logic [2:0] sh,
                            input logic signed [MB-1:0] b, input logic signed [MB-1:0] thr,
                            input bit scramble, output int done_at, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; in_spikes = spk; shift_cfg = sh; bias_cfg = b; threshold = thr;
        done_at = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (busy) busy_cnt++;
            if (busy && !done && k <= N) begin
                cap_w[k-1]    = dp_weights;
                cap_in[k-1]   = dp_inputs;
                cap_last[k-1] = dp_last_membrane;
                cap_bias[k-1] = dp_bias;
            end
            if (done) begin
                done_at = k;
                cap_spk = out_spikes;
                break;
            end
            if (scramble) begin
                in_spikes = S'($urandom); shift_cfg = 3'($urandom);
                bias_cfg  = MB'($urandom); threshold = MB'($urandom);
                wr_en = 1'($urandom); wr_addr = 3'($urandom); wr_data = S'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (done_at < 0) check("done_timeout", 0, 1);
    endtask

    task automatic model_step(input logic [S-1:0] spk, input int sh, input int b, input int thr);
        logic [N-1:0] e;
        int nv;
        e = '0;
        for (int n = 0; n < N; n++) begin
            exp_last[n] = m_mem[n];
            exp_w[n]    = m_w[n];
            nv = dp_model(m_mem[n], spk, m_w[n], sh, b);
            if (nv >= thr) begin
                e[n] = 1'b1;
                m_mem[n] = nv - thr;
            end else begin
                m_mem[n] = nv;
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, busy_cnt, dones;
        logic [S-1:0]         rs;
        logic [2:0]           rsh;
        logic signed [MB-1:0] rb, rt;

        tbl[0] = '{8'h01, 3'd0, 5'sd0,  5'sd3, 8'h00};
        tbl[1] = '{8'h01, 3'd0, 5'sd0,  5'sd3, 8'h00};
        tbl[2] = '{8'h01, 3'd0, 5'sd0,  5'sd3, 8'h20};
        tbl[3] = '{8'h01, 3'd0, 5'sd0,  5'sd3, 8'h00};
        tbl[4] = '{8'h01, 3'd0, 5'sd1,  5'sd3, 8'h20};
        tbl[5] = '{8'h00, 3'd0, 5'sd2,  5'sd3, 8'hDF};
        tbl[6] = '{8'h00, 3'd1, 5'sd0,  5'sd3, 8'h00};
        tbl[7] = '{8'h01, 3'd0, -5'sd2, 5'sd3, 8'h00};
        tbl[8] = '{8'h01, 3'd0, 5'sd0,  5'sd1, 8'h20};

        // Reset state; inputs are non-zero so parked dp_* outputs are meaningful.
        in_spikes = 8'hA5; shift_cfg = 3'd5; bias_cfg = 5'sd4;
        do_reset();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_out_spikes", out_spikes, 0);
        check("rst_dp_inputs", dp_inputs, 0);
        check("rst_dp_weights", dp_weights, 0);
        check("rst_dp_shift", dp_shift, 0);
        check("rst_dp_bias", int'(dp_bias), 0);
        check("rst_dp_last", int'(dp_last_membrane), 0);

        // All-zero weights: latency and busy length.
        run_step(8'hA5, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        check("t1_done_latency", done_at, 9);
        check("t1_busy_cycles", busy_cnt, 9);
        check("t1_out_spikes", cap_spk, 8'h00);
        @(negedge clk);
        check("t1_done_pulse_width", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_wr_ready", wr_ready, 1);
        check("t1_hold_spikes", out_spikes, 8'h00);

        // Single full-weight neuron.
        do_reset();
        wr(3'd2, 8'hFF);
        run_step(8'hFF, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        check("t2_done_latency", done_at, 9);
        check("t2_cycle3_weights", cap_w[2], 8'hFF);
        check("t2_cycle3_inputs", cap_in[2], 8'hFF);
        check("t2_cycle3_last", int'(cap_last[2]), 0);
        check("t2_cycle2_weights", cap_w[1], 8'h00);
        check("t2_out_spikes", cap_spk, 8'h04);
        run_step(8'h00, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        check("t2_stored_membrane", int'(cap_last[2]), 5);
        check("t2_second_spikes", cap_spk, 8'h04);

        // Vector table: neuron 5 integrates, then bias/shift/sign cases.
        do_reset();
        wr(3'd5, 8'h01);
        for (int i = 0; i < 9; i++) begin
            run_step(tbl[i].spk, tbl[i].sh, tbl[i].b, tbl[i].thr, 1'b0, done_at, busy_cnt);
            check($sformatf("tbl%0d_latency", i), done_at, 9);
            check($sformatf("tbl%0d_spikes", i), cap_spk, tbl[i].exp);
        end

        // Write and start during RUN are ignored.
        do_reset();
        wr(3'd3, 8'h3C);
        @(negedge clk);
        start = 1'b1; in_spikes = 8'hFF; shift_cfg = 3'd0; bias_cfg = 5'sd0; threshold = 5'sd3;
        dones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            if (done) dones++;
            if (k == 4) begin
                check("t4_wr_ready_run", wr_ready, 0);
                check("t4_busy_run", busy, 1);
                check("t4_active_weights", dp_weights, 8'h3C);
                wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hC3;
            end
            if (k == 5) start = 1'b1;
        end
        start = 1'b0;
        wr_en = 1'b0;
        check("t4_single_done", dones, 1);
        run_step(8'h00, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        check("t4_weight_unchanged", cap_w[3], 8'h3C);

        // Reset in RUN cycle 4.
        do_reset();
        wr(3'd1, 8'hFF);
        run_step(8'hFF, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        check("t5_pre_spikes", cap_spk, 8'h02);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t5_busy_before_reset", busy, 1);
        do_reset();
        check("t5_busy_after_reset", busy, 0);
        check("t5_done_after_reset", done, 0);
        check("t5_spikes_after_reset", out_spikes, 0);
        check("t5_wr_ready_after_reset", wr_ready, 1);
        run_step(8'h00, 3'd0, 5'sd0, 5'sd3, 1'b0, done_at, busy_cnt);
        for (int n = 0; n < N; n++)
            check($sformatf("t5_last_%0d", n), int'(cap_last[n]), 0);
        check("t5_weights_cleared", cap_w[1], 8'h00);

        // Start and write in the same IDLE cycle.
        do_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h5A; start = 1'b1;
        in_spikes = 8'hFF; threshold = 5'sd3;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        check("t6_busy", busy, 1);
        check("t6_first_weights", dp_weights, 8'h5A);
        dones = 0;
        for (int k = 0; k < 20 && dones == 0; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6_done_seen", dones, 1);

        // Randomized timesteps against the reference model.
        do_reset();
        for (int i = 0; i < 12; i++) wr(3'($urandom), S'($urandom));
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0) wr(3'($urandom), S'($urandom));
            rs  = S'($urandom);
            rsh = 3'($urandom_range(0, 7));
            rb  = MB'(int'($urandom_range(0, 8)) - 4);
            rt  = MB'($urandom_range(1, 15));
            model_step(rs, int'(rsh), int'(rb), int'(rt));
            run_step(rs, rsh, rb, rt, 1'b1, done_at, busy_cnt);
            check("rnd_latency", done_at, 9);
            check("rnd_spikes", cap_spk, exp_q.pop_front());
            check("rnd_inputs", cap_in[N-1], rs);
            check("rnd_bias", int'(cap_bias[N-1]), int'(rb));
            for (int n = 0; n < N; n++) begin
                check($sformatf("rnd_w_%0d", n), cap_w[n], exp_w[n]);
                check($sformatf("rnd_last_%0d", n), int'(cap_last[n]), exp_last[n]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/snn_layer_scheduler.md
Name: snn_layer_scheduler

Overview:
- Time-multiplexes one shared leaky-integrator datapath (inputs, weights, shift, bias, last_membrane → new_membrane) across NEURONS virtual neurons of one layer.
- Holds per-neuron weight rows and membrane state in internal register arrays.
- On each timestep `start`, the block sequences every neuron through the datapath, one neuron per cycle, and thresholds the result.
- Produces a spike vector for the next layer.

Parameters:
- NEURONS, 8, number of virtual neurons sharing the datapath (power of 2, ≥2).
- SYNAPSES, 8, input spikes and weight bits per neuron.
- MEMBRANE_BITS, $clog2(SYNAPSES)+2, signed membrane width; matches the datapath.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin one timestep
- in_spikes  in  SYNAPSES  layer input spikes for this timestep
- shift_cfg  in  3  decay shift for the layer
- bias_cfg  in  MEMBRANE_BITS  signed bias for the layer
- threshold  in  MEMBRANE_BITS  signed firing threshold (>0)
- wr_en  in  1  weight row write strobe
- wr_addr  in  $clog2(NEURONS)  neuron index for the write
- wr_data  in  SYNAPSES  weight row
- wr_ready  out  1  high when weight writes are accepted
- dp_inputs  out  SYNAPSES  to datapath inputs
- dp_weights  out  SYNAPSES  to datapath weights
- dp_shift  out  3  to datapath shift
- dp_bias  out  MEMBRANE_BITS  to datapath bias
- dp_last_membrane  out  MEMBRANE_BITS  to datapath last_membrane
- dp_new_membrane  in  MEMBRANE_BITS  from datapath, combinational same cycle
- busy  out  1  timestep in progress
- done  out  1  one-cycle pulse: spikes valid
- out_spikes  out  NEURONS  spike vector of the last completed timestep

Behaviour:
- Reset (any state, including mid-run):
  - FSM goes to IDLE.
  - idx=0; all membranes=0; all weight rows=0.
  - out_spikes=0, busy=0, done=0, wr_ready=1.
  - All dp_* outputs=0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - busy=0, wr_ready=1.
  - A write (wr_en=1) stores wr_data into weights[wr_addr] at the clock edge.
  - start=1 latches in_spikes, shift_cfg, bias_cfg and threshold into shadow registers, clears the spike accumulator, sets idx=0, and moves to RUN.
  - If start and wr_en are high in the same cycle, the write is performed and is visible to the run.
- RUN:
  - busy=1, wr_ready=0.
  - wr_en is ignored; no weight update occurs.
  - Combinationally drives:
    - dp_inputs = latched spikes
    - dp_weights = weights[idx]
    - dp_shift and dp_bias = latched values
    - dp_last_membrane = membrane[idx]
  - Each cycle, with s = (dp_new_membrane >= latched threshold), signed compare:
    - acc[idx] <= s
    - membrane[idx] <= s ? dp_new_membrane - threshold : dp_new_membrane (reset by subtraction)
    - The subtraction cannot underflow, because the operand is ≥ threshold > 0.
  - idx increments each cycle.
  - When idx==NEURONS-1, the next state is FINISH and idx wraps to 0.
- FINISH:
  - One cycle: out_spikes <= acc, done=1 for exactly this cycle, busy=1.
  - The next state is IDLE.
- Latency: start high at edge T → done high in cycle T+NEURONS+1; out_spikes updated in the same cycle as done.
  - The next start is accepted from the cycle after done.
- start while busy (RUN or FINISH) is ignored; it is not queued.
- in_spikes, shift_cfg, bias_cfg and threshold changes during a run have no effect.
- out_spikes holds its value between timesteps.
- dp_* outputs in IDLE and FINISH: all zero.
  - Their value is don't-care to the datapath, but is fixed at zero for determinism.

Test Plan:
- Reset then start, all weights 0, bias_cfg=0, threshold=3 → done pulses exactly 9 cycles after start (NEURONS=8); out_spikes=8'h00; busy high 9 cycles.
- Write weights[2]=8'hFF, in_spikes=8'hFF, shift_cfg=0, bias_cfg=0, threshold=3; one start → check the datapath is driven with idx 2 in RUN cycle 3, expect out_spikes[2]=1 only, and stored membrane[2] = returned value − 3.
- Repeat start 4 timesteps with only neuron 5 receiving sub-threshold input (net +1 per step, shift_cfg=0), threshold=3 → out_spikes[5] = 0, 0, 1, 0 across steps (membrane 1, 2, 3→0, 1).
- Assert wr_en during RUN targeting the active neuron → wr_ready=0, weight row unchanged on readback via the next run's dp_weights; start pulsed mid-run → no extra done.
- Assert reset at RUN cycle 4 → next cycle busy=0, out_spikes=0, membranes zero (next run with zero input yields dp_last_membrane=0 for all idx).
- Start and wr_en to neuron 0 in the same IDLE cycle → new row appears on dp_weights in the first RUN cycle.
